// File: rtl/spi_rx_frame_ctrl_if.sv
// Bus between the SPI receive frame controller and its deserializer/CPU side.
// master drives words and CPU controls; slave is the frame controller.
interface spi_rx_frame_ctrl_if #(parameter int AW = 3);
  logic          word_valid;
  logic [15:0]   word_data;
  logic          slaveChipSelectN;
  logic          rd_en;
  logic [15:0]   rd_data;
  logic          rd_valid;
  logic          frame_ack;
  logic          clr_err;
  logic          frame_ready;
  logic [7:0]    frame_cmd;
  logic [7:0]    frame_len;
  logic [AW:0]   fifo_count;
  logic          overrun;
  logic          frame_err;
  logic          irq;

  modport master (
    output word_valid, word_data, slaveChipSelectN, rd_en, frame_ack, clr_err,
    input  rd_data, rd_valid, frame_ready, frame_cmd, frame_len, fifo_count,
           overrun, frame_err, irq
  );

  modport slave (
    input  word_valid, word_data, slaveChipSelectN, rd_en, frame_ack, clr_err,
    output rd_data, rd_valid, frame_ready, frame_cmd, frame_len, fifo_count,
           overrun, frame_err, irq
  );
endinterface

// File: rtl/spi_rx_frame_ctrl.sv
// SPI receive frame controller: parses header + len payload words per chip-select
// transaction, buffers payload in a FIFO for the CPU, flags overrun/abort.
module spi_rx_frame_ctrl #(
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic clock,
  input  logic reset,
  spi_rx_frame_ctrl_if.slave bus
);

  typedef enum logic [1:0] {IDLE, PAYLOAD, DONE, DROP} state_t;

  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  state_t        state, state_nx;
  logic [15:0]   mem [DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic [AW:0]   count;
  logic [7:0]    cnt, cmd, len;
  logic [15:0]   rd_data;
  logic          rd_valid, overrun, frame_err, done_d;
  logic          push, pop, flush, hdr, ovr_set, err_set;

  always_comb begin
    state_nx = state;
    push     = 1'b0;
    flush    = 1'b0;
    hdr      = 1'b0;
    ovr_set  = 1'b0;
    err_set  = 1'b0;
    pop      = bus.rd_en && (count != '0);
    case (state)
      IDLE: begin
        if (bus.word_valid) begin
          hdr      = 1'b1;
          state_nx = (bus.word_data[7:0] == 8'd0) ? DONE : PAYLOAD;
        end
      end
      PAYLOAD: begin
        // Abort beats everything else, including a same-cycle pop.
        if (bus.slaveChipSelectN) begin
          flush    = 1'b1;
          err_set  = 1'b1;
          pop      = 1'b0;
          state_nx = IDLE;
        end else if (bus.word_valid) begin
          if (count == FULL && !pop) begin
            ovr_set  = 1'b1;
            state_nx = DROP;
          end else begin
            push = 1'b1;
            if (cnt + 8'd1 == len) state_nx = DONE;
          end
        end
      end
      DONE: begin
        if (bus.word_valid) ovr_set  = 1'b1;
        if (bus.frame_ack)  state_nx = IDLE;
      end
      DROP: begin
        if (bus.slaveChipSelectN) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      cmd       <= '0;
      len       <= '0;
      overrun   <= 1'b0;
      frame_err <= 1'b0;
      done_d    <= 1'b0;
    end else begin
      state  <= state_nx;
      done_d <= (state == DONE);
      if (hdr) begin
        cmd <= bus.word_data[15:8];
        len <= bus.word_data[7:0];
        cnt <= '0;
      end else if (push) begin
        cnt <= cnt + 8'd1;
      end
      // A new error in the same cycle as clr_err stays set.
      overrun   <= ovr_set | (overrun   & ~bus.clr_err);
      frame_err <= err_set | (frame_err & ~bus.clr_err);
    end
  end

  always_ff @(posedge clock) begin
    if (push) mem[wptr] <= bus.word_data;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wptr     <= '0;
      rptr     <= '0;
      count    <= '0;
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= pop;
      if (flush) begin
        wptr  <= '0;
        rptr  <= '0;
        count <= '0;
      end else begin
        if (push) wptr <= wptr + 1'b1;
        if (pop) begin
          rd_data <= mem[rptr];
          rptr    <= rptr + 1'b1;
        end
        case ({push, pop})
          2'b10:   count <= count + 1'b1;
          2'b01:   count <= count - 1'b1;
          default: count <= count;
        endcase
      end
    end
  end

  assign bus.rd_data     = rd_data;
  assign bus.rd_valid    = rd_valid;
  assign bus.frame_ready = (state == DONE);
  assign bus.irq         = (state == DONE) && !done_d;
  assign bus.frame_cmd   = cmd;
  assign bus.frame_len   = len;
  assign bus.fifo_count  = count;
  assign bus.overrun     = overrun;
  assign bus.frame_err   = frame_err;

endmodule
